serial_subtractor: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 32 +++
 rtl/full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 147 ++++++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared types and helpers for the bit-serial subtractor.
//   state_e       - FSM encoding (IDLE, SHIFT, DONE)
//   full_sub      - 1-bit full subtract, returns {bout, d}
//   borrow_seed   - initial borrow-flop value for the selected operation
//   borrow_result - final borrow_out for the selected operation
// Add mode reuses the subtractor: a + b + cin = a - ~b - ~cin, so the borrow
// flop starts at ~cin and the carry out is the inverted final borrow.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, d};
    endfunction

    function automatic logic borrow_seed(input logic borrow_in, input logic add_mode);
        return borrow_in ^ add_mode;
    endfunction

    function automatic logic borrow_result(input logic final_borrow, input logic add_mode);
        return final_borrow ^ add_mode;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit combinational full-subtractor cell.
//   a, b, bin -> d = a - b - bin (mod 2), bout = borrow out
//   inv_b     -> inverts b before subtracting (used for add mode)
module full_subtractor
    import serial_arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    input  logic inv_b,
    output logic d,
    output logic bout
);

    logic [1:0] res;

    always_comb res = full_sub(a, b ^ inv_b, bin);

    assign d    = res[0];
    assign bout = res[1];

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first diff = a - b - borrow_in over WIDTH
// cycles using one full_subtractor cell.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   start             - request, sampled only in IDLE
//   a, b, borrow_in   - operands, captured on accepted start
//   add_mode          - (SERIAL_SUB_ADD_MODE_EN only) 1 = a + b + carry_in
//   busy              - high while shifting (WIDTH cycles)
//   done              - one-cycle pulse, diff/borrow_out valid
//   diff, borrow_out  - result, held until the next accepted start
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             add_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int SW    = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    // Only WIDTH-1 partial bits are stored; the last bit comes straight from
    // the cell when the result is copied out.
    logic [SW-1:0]    sd_q, sd_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;

    logic             add_sel;   // operation of the op in flight
    logic             add_req;   // operation requested with start
    logic             cell_d;
    logic             cell_bout;

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic add_q, add_d;
    assign add_sel = add_q;
    assign add_req = add_mode;
`else
    assign add_sel = 1'b0;
    assign add_req = 1'b0;
`endif

    full_subtractor u_cell (
        .a     (sa_q[0]),
        .b     (sb_q[0]),
        .bin   (brw_q),
        .inv_b (add_sel),
        .d     (cell_d),
        .bout  (cell_bout)
    );

    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        sd_d         = sd_q;
        brw_d        = brw_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
        add_d        = add_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sa_d    = a;
                    sb_d    = b;
                    brw_d   = borrow_seed(borrow_in, add_req);
                    cnt_d   = '0;
                    sd_d    = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    add_d   = add_mode;
`endif
                end
            end
            SHIFT: begin
                // New bit enters at the MSB so after WIDTH shifts bit 0 is LSB.
                sd_d  = SW'({cell_d, sd_q} >> 1);
                brw_d = cell_bout;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d      = DONE;
                    diff_d       = {cell_d, sd_q};
                    borrow_out_d = borrow_result(cell_bout, add_sel);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            sd_q         <= '0;
            brw_q        <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            sd_q         <= sd_d;
            brw_q        <= brw_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_q        <= add_d;
`endif
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         borrow_in;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic         add_mode;
`endif
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .add_mode   (add_mode),
`endif
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    // ---- behavioural model: remaining-cycle countdown + arithmetic result ----
    int           m_cnt  = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_bo   = 1'b0;
    logic [W-1:0] p_diff = '0;
    logic         p_bo   = 1'b0;
    logic         chk_en = 1'b0;

    always @(posedge clk) begin
        int  r;
        logic am;
`ifdef SERIAL_SUB_ADD_MODE_EN
        am = add_mode;
`else
        am = 1'b0;
`endif
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bo   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_diff <= p_diff;
                    m_bo   <= p_bo;
                end
            end else if (!m_done && start) begin
                m_cnt <= W;
                if (am) begin
                    r = int'(a) + int'(b) + int'(borrow_in);
                    p_bo <= (r >= (1 << W));
                end else begin
                    r = int'(a) - int'(b) - int'(borrow_in);
                    p_bo <= (r < 0);
                end
                p_diff <= r[W-1:0];
            end
        end
    end

    // ---- per-cycle compare against the model ----
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (busy !== (m_cnt > 0) || done !== m_done || diff !== m_diff || borrow_out !== m_bo) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t got busy=%0b done=%0b diff=%02h bo=%0b exp busy=%0b done=%0b diff=%02h bo=%0b",
                         $time, busy, done, diff, borrow_out, (m_cnt > 0), m_done, m_diff, m_bo);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, check literal results.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input logic tadd, input logic [W-1:0] ed, input logic eb);
        int bc = 0;
        int guard = 0;
        @(negedge clk);
        a = ta; b = tb_; borrow_in = tbin; start = 1'b1;
`ifdef SERIAL_SUB_ADD_MODE_EN
        add_mode = tadd;
`else
        if (tadd) $display("note: add op skipped");
`endif
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); borrow_in = 1'b1;
        while (!done && guard < 40) begin
            if (busy) bc++;
            @(negedge clk);
            guard++;
        end
        check({name, "_done_seen"}, int'(done), 1);
        check({name, "_busy_cycles"}, bc, W);
        check({name, "_diff"}, int'(diff), int'(ed));
        check({name, "_bo"}, int'(borrow_out), int'(eb));
        @(negedge clk);
        check({name, "_done_once"}, int'(done), 0);
    endtask

    initial begin
        int guard;
        int dn;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        add_mode = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bo",   int'(borrow_out), 0);
        rst_n = 1'b1;

        run_op("t1_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h1E, 1'b0);
        run_op("t2_wrap",  8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1);
        run_op("t3_bin",   8'h10, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0);
        run_op("t3_ffff",  8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

        // Second start while busy must be ignored.
        @(negedge clk);
        a = 8'h80; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);                // accepted at edge N
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h00; b = 8'h00; start = 1'b1;   // sampled at edge N+3
        @(negedge clk);
        start = 1'b0;
        guard = 0; dn = 0;
        while (guard < 12) begin
            if (done) dn++;
            if (done) check("t4_diff", int'(diff), 8'h7F);
            @(negedge clk);
            guard++;
        end
        check("t4_done_pulses", dn, 1);
        check("t4_diff_hold", int'(diff), 8'h7F);
        check("t4_busy_idle", int'(busy), 0);

        // Mid-operation reset.
        @(negedge clk);
        a = 8'h33; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;                  // sampled at edge N+4
        @(negedge clk);
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(done), 0);
        check("t5_diff", int'(diff), 0);
        check("t5_bo",   int'(borrow_out), 0);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            check("t5_no_done", int'(done), 0);
        end
        run_op("t5_fresh", 8'hC8, 8'h64, 1'b0, 1'b0, 8'h64, 1'b0);

`ifdef SERIAL_SUB_ADD_MODE_EN
        run_op("t6_add_ff01", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
        run_op("t6_add_1234", 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0);
        run_op("t6_sub_after", 8'h05, 8'h07, 1'b0, 1'b0, 8'hFE, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
